// File: rtl/sw_debounce.sv
`default_nettype none
// ============================================================================
//  Module   : sw_debounce
//  Purpose  : Synchronise raw switch pins into clk and debounce each channel,
//             producing a clean level plus one-cycle rise/fall pulses.
//  Revision : 1.0  initial release
// ============================================================================
module sw_debounce #(
  parameter int SW_NUM    = 3,
  parameter int DB_CYCLES = 1000000,
  parameter int SW_INV    = 0
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [SW_NUM-1:0] sw_raw,
  output logic [SW_NUM-1:0] sw,
  output logic [SW_NUM-1:0] sw_rise,
  output logic [SW_NUM-1:0] sw_fall
);

  localparam int                CNT_W      = $clog2(DB_CYCLES);
  localparam logic [CNT_W-1:0]  C_CNT_MAX  = CNT_W'(DB_CYCLES - 1);
  localparam logic [SW_NUM-1:0] C_INV_MASK = (SW_INV != 0) ? {SW_NUM{1'b1}} : {SW_NUM{1'b0}};

  logic [SW_NUM-1:0] w_raw;
  logic [SW_NUM-1:0] r_s1;
  logic [SW_NUM-1:0] r_s2;

  assign w_raw = sw_raw ^ C_INV_MASK;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_s1 <= '0;
      r_s2 <= '0;
    end else begin
      r_s1 <= w_raw;
      r_s2 <= r_s1;
    end
  end

  generate
    for (genvar gi = 0; gi < SW_NUM; gi++) begin : g_ch
      logic [CNT_W-1:0] r_cnt;
      logic             r_sw;
      logic             r_rise;
      logic             r_fall;
      logic             w_diff;
      logic             w_done;

      assign w_diff = r_s2[gi] ^ r_sw;
      // Counter only ever reaches C_CNT_MAX while mismatched, then clears: no wrap.
      assign w_done = w_diff && (r_cnt == C_CNT_MAX);

      always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
          r_cnt  <= '0;
          r_sw   <= 1'b0;
          r_rise <= 1'b0;
          r_fall <= 1'b0;
        end else begin
          r_rise <= w_done && r_s2[gi];
          r_fall <= w_done && !r_s2[gi];
          if (!w_diff || w_done) begin
            r_cnt <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
          if (w_done) begin
            r_sw <= r_s2[gi];
          end
        end
      end

      assign sw[gi]      = r_sw;
      assign sw_rise[gi] = r_rise;
      assign sw_fall[gi] = r_fall;
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_sw_debounce.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sw_debounce
//  Purpose  : Self-checking bench for sw_debounce (SW_INV=0 and SW_INV=1).
//  Revision : 1.0  initial release
// ============================================================================
module tb_sw_debounce;

  localparam int DB = 4;

  logic       clk    = 1'b0;
  logic       resetn = 1'b1;
  logic [2:0] raw0   = 3'b111;
  logic [2:0] raw1   = 3'b111;
  logic [2:0] sw0, rise0, fall0;
  logic [2:0] sw1, rise1, fall1;

  sw_debounce #(.SW_NUM(3), .DB_CYCLES(DB), .SW_INV(0)) u_dut0 (
    .clk     (clk),
    .resetn  (resetn),
    .sw_raw  (raw0),
    .sw      (sw0),
    .sw_rise (rise0),
    .sw_fall (fall0)
  );

  sw_debounce #(.SW_NUM(3), .DB_CYCLES(DB), .SW_INV(1)) u_dut1 (
    .clk     (clk),
    .resetn  (resetn),
    .sw_raw  (raw1),
    .sw      (sw1),
    .sw_rise (rise1),
    .sw_fall (fall1)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [2:0] act, input logic [2:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: a level is accepted once the synchronised input has disagreed
  // with it for each of the last DB samples; synchroniser is a 2-deep delay.
  logic [2:0] m_s1   [2];
  logic [2:0] m_s2   [2];
  logic [2:0] m_sw   [2];
  logic [2:0] m_rise [2];
  logic [2:0] m_fall [2];
  logic [2:0] m_hist [2][DB];

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_s1[d] = '0; m_s2[d] = '0; m_sw[d] = '0; m_rise[d] = '0; m_fall[d] = '0;
      for (int k = 0; k < DB; k++) m_hist[d][k] = '0;
    end
  endtask

  task automatic model_edge();
    logic [2:0] eff, nsw;
    bit         all_diff;
    for (int d = 0; d < 2; d++) begin
      eff = (d == 0) ? raw0 : ~raw1;
      for (int k = 0; k < DB - 1; k++) m_hist[d][k] = m_hist[d][k+1];
      m_hist[d][DB-1] = m_s2[d];
      nsw = m_sw[d];
      for (int c = 0; c < 3; c++) begin
        all_diff = 1'b1;
        for (int k = 0; k < DB; k++)
          if (m_hist[d][k][c] == m_sw[d][c]) all_diff = 1'b0;
        if (all_diff) nsw[c] = ~m_sw[d][c];
      end
      m_rise[d] = nsw & ~m_sw[d];
      m_fall[d] = ~nsw & m_sw[d];
      m_sw[d]   = nsw;
      m_s2[d]   = m_s1[d];
      m_s1[d]   = eff;
    end
  endtask

  task automatic step(input logic [2:0] r0, input logic [2:0] r1);
    raw0 = r0;
    raw1 = r1;
    @(posedge clk);
    model_edge();
    #1;
    chk("model_sw0",   sw0,   m_sw[0]);
    chk("model_rise0", rise0, m_rise[0]);
    chk("model_fall0", fall0, m_fall[0]);
    chk("model_sw1",   sw1,   m_sw[1]);
    chk("model_rise1", rise1, m_rise[1]);
    chk("model_fall1", fall1, m_fall[1]);
  endtask

  // Asserts reset mid-cycle, checks the asynchronous clear, releases mid-cycle.
  task automatic do_reset();
    resetn = 1'b0;
    model_reset();
    #1;
    chk("rst_sw0", sw0, 3'b000);   chk("rst_rise0", rise0, 3'b000); chk("rst_fall0", fall0, 3'b000);
    chk("rst_sw1", sw1, 3'b000);   chk("rst_rise1", rise1, 3'b000); chk("rst_fall1", fall1, 3'b000);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_hold_sw0", sw0, 3'b000);
    resetn = 1'b1;
  endtask

  typedef struct {
    logic [2:0] raw;
    logic [2:0] sw;
    logic [2:0] rise;
    logic [2:0] fall;
  } vec_t;

  vec_t tv[7];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int         nr, nf, hi, rise_at;
    logic [2:0] m0, m1;

    tv[0] = '{3'b111, 3'b000, 3'b000, 3'b000};
    tv[1] = '{3'b111, 3'b000, 3'b000, 3'b000};
    tv[2] = '{3'b111, 3'b000, 3'b000, 3'b000};
    tv[3] = '{3'b111, 3'b000, 3'b000, 3'b000};
    tv[4] = '{3'b111, 3'b000, 3'b000, 3'b000};
    tv[5] = '{3'b111, 3'b111, 3'b111, 3'b000};
    tv[6] = '{3'b111, 3'b111, 3'b000, 3'b000};

    // Power-up with all switches held high
    #2;
    raw0 = 3'b111;
    do_reset();
    for (int i = 0; i < 7; i++) begin
      step(tv[i].raw, 3'b111);
      chk("t1_sw",   sw0,   tv[i].sw);
      chk("t1_rise", rise0, tv[i].rise);
      chk("t1_fall", fall0, tv[i].fall);
    end

    // Single channel rise, others untouched
    raw0 = 3'b000;
    do_reset();
    repeat (3) step(3'b000, 3'b111);
    for (int k = 1; k <= 7; k++) begin
      step(3'b001, 3'b111);
      if (k == 5) chk("t2_sw_before", sw0, 3'b000);
      if (k == 6) begin
        chk("t2_sw_after", sw0, 3'b001);
        chk("t2_rise", rise0, 3'b001);
      end
      if (k == 7) chk("t2_rise_once", rise0, 3'b000);
    end

    // Short pulse rejected, full-length pulse accepted then released
    nr = 0; nf = 0; hi = 0;
    for (int k = 0; k < 11; k++) begin
      step((k < 3) ? 3'b011 : 3'b001, 3'b111);
      nr += int'(rise0[1]); nf += int'(fall0[1]); hi |= int'(sw0[1]);
    end
    chk_int("t3_short_sw",    hi, 0);
    chk_int("t3_short_pulse", nr + nf, 0);
    nr = 0; nf = 0; hi = 0;
    for (int k = 0; k < 14; k++) begin
      step((k < 4) ? 3'b011 : 3'b001, 3'b111);
      nr += int'(rise0[1]); nf += int'(fall0[1]); hi |= int'(sw0[1]);
    end
    chk_int("t3_long_sw_high", hi, 1);
    chk_int("t3_long_rise",    nr, 1);
    chk_int("t3_long_fall",    nf, 1);
    chk("t3_long_final", sw0, 3'b001);

    // Bounce 1,0,1,0,1 then held high on channel 2
    nr = 0; rise_at = -1;
    for (int j = 1; j <= 14; j++) begin
      step((j <= 5 && (j % 2) == 0) ? 3'b001 : 3'b101, 3'b111);
      if (rise0[2]) begin
        nr++;
        rise_at = j;
      end
    end
    chk_int("t4_rise_count", nr, 1);
    chk_int("t4_rise_time",  rise_at, 10);
    chk("t4_final", sw0, 3'b101);

    // Reset while channel 1 is mid-count
    repeat (4) step(3'b111, 3'b111);
    chk("t5_pre_reset", sw0, 3'b101);
    do_reset();
    for (int k = 1; k <= 6; k++) begin
      step(3'b111, 3'b111);
      if (k == 5) chk("t5_restart_before", sw0, 3'b000);
      if (k == 6) begin
        chk("t5_restart_sw", sw0, 3'b111);
        chk("t5_restart_rise", rise0, 3'b111);
      end
    end

    // Active-low instance: pin 2 driven low means pressed
    for (int k = 1; k <= 7; k++) begin
      step(3'b111, 3'b011);
      if (k == 5) chk("t6_inv_before", sw1, 3'b000);
      if (k == 6) begin
        chk("t6_inv_sw", sw1, 3'b100);
        chk("t6_inv_rise", rise1, 3'b100);
      end
    end

    // Randomised traffic at several bounce densities, with a mid-run reset
    for (int ph = 0; ph < 3; ph++) begin
      for (int n = 0; n < 1000; n++) begin
        for (int c = 0; c < 3; c++) begin
          m0[c] = ($urandom_range(0, 2 + 4 * ph) == 0);
          m1[c] = ($urandom_range(0, 2 + 4 * ph) == 0);
        end
        step(raw0 ^ m0, raw1 ^ m1);
        if (ph == 1 && n == 500) do_reset();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
